// File: rtl/rs_issue_scheduler_if.sv
// Issue-scheduler bundle between the reservation station, instruction fetcher and ALU.
// The station/ALU side drives allocation, readiness and completion; the scheduler drives issue/release/occupancy.
interface rs_issue_scheduler_if #(
    parameter int RS_SIZE = 16,
    parameter int IDX_W   = 5
);
    logic [IDX_W-1:0]   alloc_index;
    logic [RS_SIZE-1:0] operand_ready;
    logic               valid_from_al_unit;
    logic               exec_valid;
    logic [IDX_W-1:0]   exec_index;
    logic [IDX_W-1:0]   release_index;
    logic [IDX_W-1:0]   occupancy;
    logic               is_rs_station_full;

    modport master (
        output alloc_index, operand_ready, valid_from_al_unit,
        input  exec_valid, exec_index, release_index, occupancy, is_rs_station_full
    );

    modport slave (
        input  alloc_index, operand_ready, valid_from_al_unit,
        output exec_valid, exec_index, release_index, occupancy, is_rs_station_full
    );
endinterface

// File: rtl/rs_issue_scheduler.sv
// Age-ordered issue scheduler: picks the oldest live, ready, not-in-flight slot each time the
// single ALU is free, and tracks slot liveness, allocation age and occupancy.
module rs_issue_scheduler #(
    parameter int RS_SIZE = 16,
    parameter int IDX_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                reset_from_rob_bus,
    rs_issue_scheduler_if.slave bus
);
    typedef enum logic [0:0] {IDLE, WAITING} state_t;

    state_t             state_reg, state_next;
    logic [RS_SIZE-1:0] live_reg, inflight_reg;
    // older_reg[i][j]: slot i+1 was allocated before slot j+1
    logic [RS_SIZE-1:0] older_reg  [RS_SIZE];
    logic [RS_SIZE-1:0] older_next [RS_SIZE];
    logic [IDX_W-1:0]   last_exec_reg, exec_index_reg, release_index_reg, occupancy_reg;
    logic               exec_valid_reg;

    logic               flush;
    logic               issue, release_fire, alloc_ok;
    logic [RS_SIZE-1:0] cand, is_oldest, alloc_onehot, release_onehot, alloc_fire;
    logic [IDX_W-1:0]   oldest_idx;

    assign flush = rst | reset_from_rob_bus;

    generate
        for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_slot
            logic [RS_SIZE-1:0] older_col;
            for (genvar gj = 0; gj < RS_SIZE; gj++) begin : g_col
                assign older_col[gj] = older_reg[gj][gi];
            end
            assign alloc_onehot[gi]   = (bus.alloc_index == IDX_W'(gi + 1));
            assign release_onehot[gi] = release_fire & (last_exec_reg == IDX_W'(gi + 1));
            assign cand[gi]           = live_reg[gi] & bus.operand_ready[gi] & ~inflight_reg[gi];
            // Only one candidate can have no older candidate, so this is one-hot or zero.
            assign is_oldest[gi]      = cand[gi] & ~|(cand & older_col);
            assign older_next[gi]     = alloc_fire[gi] ? '0 : (older_reg[gi] | alloc_fire);
        end
    endgenerate

    // A slot being released on this edge may be refilled on the same edge.
    assign alloc_ok   = |alloc_onehot & ~|(alloc_onehot & live_reg & ~release_onehot);
    assign alloc_fire = alloc_onehot & {RS_SIZE{alloc_ok}};

    always_comb begin
        oldest_idx = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (is_oldest[i]) oldest_idx = oldest_idx | IDX_W'(i + 1);
        end
    end

    always_comb begin
        state_next   = state_reg;
        issue        = 1'b0;
        release_fire = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|cand) begin
                    issue      = 1'b1;
                    state_next = WAITING;
                end
            end
            WAITING: begin
                if (bus.valid_from_al_unit) begin
                    release_fire = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush)    state_reg <= IDLE;
        else if (rdy) state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            live_reg          <= '0;
            inflight_reg      <= '0;
            last_exec_reg     <= '0;
            exec_valid_reg    <= 1'b0;
            exec_index_reg    <= '0;
            release_index_reg <= '0;
            occupancy_reg     <= '0;
            for (int i = 0; i < RS_SIZE; i++) older_reg[i] <= '0;
        end else if (rdy) begin
            live_reg      <= (live_reg & ~release_onehot) | alloc_fire;
            inflight_reg  <= (inflight_reg & ~release_onehot) | (is_oldest & {RS_SIZE{issue}});
            for (int i = 0; i < RS_SIZE; i++) older_reg[i] <= older_next[i];
            occupancy_reg <= occupancy_reg + IDX_W'(alloc_ok) - IDX_W'(release_fire);
            exec_valid_reg <= issue;
            if (issue) begin
                exec_index_reg <= oldest_idx;
                last_exec_reg  <= oldest_idx;
            end
            release_index_reg <= release_fire ? last_exec_reg : '0;
        end
    end

    assign bus.exec_valid         = exec_valid_reg;
    assign bus.exec_index         = exec_index_reg;
    assign bus.release_index      = release_index_reg;
    assign bus.occupancy          = occupancy_reg;
    assign bus.is_rs_station_full = (occupancy_reg >= IDX_W'(RS_SIZE - 1));
endmodule
